fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer for the fifo block: pops B-bit words whenever the FIFO is non-empty and
//  enabled, and serialises each word as an 8N1-style UART frame on tx.
//  Sits directly on the fifo outputs (r_data/empty), drives the fifo rd input.
//  Counterpart of the write-side producers that push into the same fifo.
// PARAMETERS
//  B            8    data width; must match the fifo B
//  CLKS_PER_BIT 868  clk cycles per serial bit (100 MHz / 115200); minimum 2
//  STOP_BITS    1    number of stop bits, 1 or 2
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  reset         in   1  synchronous, active-high reset
//  en            in   1  1 = allowed to pop and start new frames
//  empty         in   1  fifo empty flag
//  r_data        in   B  fifo head word; valid whenever empty=0 (fall-through)
//  rd            out  1  fifo pop strobe, one cycle per word
//  tx            out  1  serial line, idle high
//  busy          out  1  1 from pop cycle+1 until the end of the stop bit(s)
//  tx_done_tick  out  1  one-cycle pulse in the last cycle of each frame
// BEHAVIOUR
//  Reset: state=IDLE, tx=1, busy=0, tx_done_tick=0, rd=0 (forced low while reset=1), counters=0.
//  rd = (state==IDLE) & en & ~empty & ~reset.
//   - Combinational from registered state.
//   - In the rd cycle, r_data is latched into shift register sreg.
//  FSM (registered):
//   IDLE  -> START when rd=1; tx=1 while in IDLE.
//   START -> tx=0 for CLKS_PER_BIT cycles, then DATA.
//   DATA  -> tx=sreg[0], LSB first; B bits, each held CLKS_PER_BIT cycles.
//            sreg shifts right and bit_cnt increments at each bit end; after bit B-1 -> STOP.
//   STOP  -> tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//            tx_done_tick=1 in the final cycle; then IDLE.
//  Latency and timing:
//   - rd at cycle N; tx falls at N+1.
//   - Frame = (1+B+STOP_BITS)*CLKS_PER_BIT cycles.
//   - Minimum pop-to-pop spacing = frame+1 (one IDLE cycle between frames).
//  busy = (state!=IDLE).
//  Counter widths:
//   - tick_cnt: $clog2(STOP_BITS*CLKS_PER_BIT) bits; wraps to 0 at terminal count.
//   - bit_cnt: $clog2(B) bits.
//  Boundary conditions:
//   - empty=1 in IDLE: stay IDLE, rd=0, tx=1 indefinitely.
//   - en deasserted mid-frame: current frame completes unchanged; no further pop.
//   - empty rising mid-frame: no effect; word already latched.
//   - r_data changes mid-frame (fifo written): no effect on tx.
//   - reset mid-frame: next edge tx=1, busy=0, IDLE; the popped word is discarded, not re-read.
//   - rd is never asserted when empty=1, so no fifo underflow.
//   - fifo full: no special handling; the first rd frees a slot.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/START/DATA/STOP) and the CLKS_PER_BIT
//  default, shared with the future UART receiver.
//  One natural sub-module: uart_bit_timer.
//   - Loadable down-counter; outputs a terminal-count pulse; reused by the receiver.
//   - Top level holds the FSM, sreg, bit_cnt and rd logic.
// TESTING
//  Bench setup:
//   - Bench instantiates fifo (B=8, W=3) + fifo_uart_tx (CLKS_PER_BIT=4, STOP_BITS=1; frame=40 cycles).
//   - 10 ns clock; stimulus applied at negedge.
//  1. reset=1 for 2 cycles, fifo empty, en=1 for 20 cycles
//     -> tx=1, rd=0, busy=0, tx_done_tick=0 throughout.
//  2. Write 0xA5, en=1 -> exactly one rd pulse. tx sequence:
//     - start 0 x4 cycles;
//     - data bits 1,0,1,0,0,1,0,1, each x4 cycles;
//     - stop 1 x4 cycles.
//     Result: tx_done_tick 40 cycles after rd; fifo empty afterwards.
//  3. Write 0x00, 0xFF, 0x3C back-to-back -> 3 rd pulses spaced 41 cycles;
//     bench decoder recovers 00, FF, 3C in order.
//  4. en=0 with 2 words queued -> no rd, tx=1 for 100 cycles.
//     Then en=1, drop en at frame cycle 10 -> frame completes; no second rd while en=0.
//  5. reset pulse at frame cycle 20 of 0x5A -> next cycle tx=1, busy=0.
//     After release with 0x81 queued -> a clean frame of 0x81 is sent.
//  6. Fill fifo (8 words, full=1), en=1 -> full drops after first rd;
//     all 8 words serialised in write order; empty=1 after 8th rd.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and default bit timing.
package fifo_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 100 MHz core clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/fifo.sv
// Generic fall-through FIFO, 2**W words of B bits; r_data shows the head whenever empty=0.
// Latency: write visible on r_data next cycle; writes when full and reads when empty are ignored.
module fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] r_mem [2**W];
    logic [W:0]   r_wr_ptr;
    logic [W:0]   r_rd_ptr;
    logic         w_do_wr;
    logic         w_do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[W] != r_rd_ptr[W]) && (r_wr_ptr[W-1:0] == r_rd_ptr[W-1:0]);
    assign w_do_wr = wr & ~full;
    assign w_do_rd = rd & ~empty;
    assign r_data  = r_mem[r_rd_ptr[W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[W-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bit_timer.sv
// Loadable down-counter for UART bit timing; o_tc is high while the count sits at zero.
// Latency: loading N gives o_tc N cycles later; no backpressure, counter parks at zero.
module uart_bit_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a fall-through FIFO and sends each as a start/LSB-first data/stop UART frame.
// Latency: tx falls the cycle after rd; rd only from IDLE, so the FIFO holds words while a frame runs.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int B            = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         empty,
    input  logic [B-1:0] r_data,
    output logic         rd,
    output logic         tx,
    output logic         busy,
    output logic         tx_done_tick
);

    localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int BW = (B > 1) ? $clog2(B) : 1;

    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LOAD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(B - 1);

    uart_state_t   r_state;
    uart_state_t   w_state_nxt;
    logic [B-1:0]  r_sreg;
    logic [BW-1:0] r_bit_cnt;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_tc;
    logic          w_shift;

    uart_bit_timer #(
        .W (TW)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    assign busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_val   = BIT_LOAD;
        w_shift      = 1'b0;
        rd           = 1'b0;
        tx           = 1'b1;
        tx_done_tick = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // reset gate keeps a held-in-reset transmitter from draining the FIFO
                if (en && !empty && !reset) begin
                    rd          = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (w_tc) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                tx = r_sreg[0];
                if (w_tc) begin
                    w_load = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_load_val  = STOP_LOAD;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tc) begin
                    tx_done_tick = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (rd) begin
                r_sreg    <= r_data;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_sreg    <= r_sreg >> 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule
